fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the address/PC width.
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 stall  input  1  SHALL be the hazard-unit hold; no new fetch issues while it is high.
REQ-006 PCsrc  input  1  SHALL be branch-taken; target = branch_pc + ImmOp.
REQ-007 branch_pc  input  WIDTH  SHALL be the PC of the resolving branch.
REQ-008 ImmOp  input  WIDTH  SHALL be the branch offset.
REQ-009 jalr_en  input  1  SHALL be the register-jump request; target = jalr_target.
REQ-010 jalr_target  input  WIDTH  SHALL be the register-jump target.
REQ-011 imem_req  output  1  SHALL be a one-cycle fetch request pulse.
REQ-012 imem_addr  output  WIDTH  SHALL be the fetch address, valid while imem_req=1.
REQ-013 imem_ack  input  1  SHALL mark imem_rdata valid, at least 1 cycle after imem_req.
REQ-014 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-015 instr_valid  output  1  SHALL flag a buffered instruction for decode.
REQ-016 instr, instr_pc  output  32, WIDTH  SHALL be the buffered instruction and its address.
REQ-017 id_ready  input  1  SHALL be decode accept; transfer occurs when instr_valid and id_ready are both 1.
REQ-018 PC  output  WIDTH  SHALL be the next address to fetch.
REQ-019 flush  output  1  SHALL pulse for one cycle on every accepted redirect.

Function
REQ-020 The FSM SHALL have states RESET_S, ISSUE and WAIT, with at most one request outstanding.
REQ-021 RESET_S SHALL go to ISSUE unconditionally on the first cycle after rst deasserts.
REQ-022 ISSUE SHALL assert imem_req with imem_addr=PC and go to WAIT iff stall=0 and (instr_valid=0 or id_ready=1); otherwise it SHALL stay in ISSUE with imem_req=0.
REQ-023 WAIT on imem_ack with the discard flag clear SHALL load instr=imem_rdata, instr_pc=PC, set instr_valid, set PC<=PC+4 (mod 2^WIDTH) and go to ISSUE.
REQ-024 instr_valid SHALL hold, with instr and instr_pc stable, until transfer; stall SHALL NOT clear it.
REQ-025 Redirect priority SHALL be jalr_en > PCsrc > sequential; target arithmetic SHALL wrap mod 2^WIDTH.
REQ-026 On a redirect, the next cycle SHALL have PC=target, flush=1 and instr_valid=0.
REQ-027 A redirect while in WAIT, or on the cycle imem_req is issued, SHALL set the discard flag and keep the FSM in WAIT.
REQ-028 A redirect in any other state SHALL move the FSM to ISSUE.
REQ-029 An imem_ack with the discard flag set SHALL be dropped (no buffer or PC update), SHALL clear the flag and SHALL move the FSM to ISSUE.
REQ-030 A redirect coincident with imem_ack SHALL win; that ack SHALL be dropped.
REQ-031 A redirect coincident with stall SHALL still be applied.
REQ-032 The best-case throughput SHALL be one instruction per 2 cycles with a 1-cycle-latency memory.

Reset
REQ-033 While rst=1 the block SHALL hold PC=RESET_PC, state=RESET_S, imem_req=0, instr_valid=0, flush=0, discard=0, and instr and instr_pc = 0.
REQ-034 An rst asserted mid-WAIT SHALL abandon the outstanding request; its later ack SHALL be ignored because the FSM is not in WAIT.

Configuration
REQ-035 With FETCH_CTRL_MISALIGN_EN defined, the block SHALL add the output misalign (1 bit), which SHALL pulse for one cycle when an accepted redirect target has [1:0]!=0.
REQ-036 With FETCH_CTRL_MISALIGN_EN defined, target bits [1:0] SHALL be forced to 0 before loading PC.
REQ-037 Without FETCH_CTRL_MISALIGN_EN, the misalign port SHALL be absent and the target SHALL be loaded unmodified.

Structure
REQ-038 Package fetch_pkg SHALL hold the state enum, the INSTR_W=32 constant and the PC increment constant (4).
REQ-039 Sub-module pc_next_sel SHALL hold the combinational priority mux and branch adder that produce next PC and redirect.

Verification
REQ-040 Reset release with RESET_PC=0 and 1-cycle ack, id_ready=1 SHALL give imem_addr 0,4,8 on alternate cycles and instr_pc 0,4,8.
REQ-041 PCsrc=1, branch_pc=0x10, ImmOp=0xFFFFFFF8 in ISSUE SHALL give flush=1 next cycle, PC=0x08 and the next imem_addr=0x08.
REQ-042 PCsrc=1 and jalr_en=1 together, jalr_target=0x100 SHALL give PC=0x100.
REQ-043 jalr_en during WAIT with ack 3 cycles later SHALL drop that ack (instr_valid stays 0), then a fetch at the target SHALL follow.
REQ-044 stall=1 for 5 cycles with a buffered instruction SHALL produce no imem_req and keep instr and instr_pc stable.
REQ-045 PC=0xFFFFFFFC fetch SHALL wrap the next PC to 0x0; with FETCH_CTRL_MISALIGN_EN, jalr_target=0x102 SHALL give misalign=1 and PC=0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch_ctrl instruction fetch block.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: redirect priority mux (jalr > branch > sequential) and branch target adder.
// With FETCH_CTRL_MISALIGN_EN defined, targets are word-aligned and a misaligned flag is produced.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_pc,
  input  logic [WIDTH-1:0] imm_op,
  input  logic             jalr_en,
  input  logic [WIDTH-1:0] jalr_target,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] seq_pc
`ifdef FETCH_CTRL_MISALIGN_EN
  ,
  output logic             misaligned
`endif
);

  logic [WIDTH-1:0] target;

  always_comb begin
    target = branch_pc + imm_op;
    if (jalr_en) begin
      target = jalr_target;
    end
  end

  assign redirect = jalr_en | branch_taken;
  assign seq_pc   = pc + WIDTH'(PC_INC);

`ifdef FETCH_CTRL_MISALIGN_EN
  assign misaligned  = |target[1:0];
  assign redirect_pc = {target[WIDTH-1:2], 2'b00};
`else
  assign redirect_pc = target;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with one-entry decode buffer and redirect/flush.
// Optional: define FETCH_CTRL_MISALIGN_EN to add the misalign output and word-align redirect targets.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               PCsrc,
  input  logic [WIDTH-1:0]   branch_pc,
  input  logic [WIDTH-1:0]   ImmOp,
  input  logic               jalr_en,
  input  logic [WIDTH-1:0]   jalr_target,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic               id_ready,
  output logic [WIDTH-1:0]   PC,
  output logic               flush
`ifdef FETCH_CTRL_MISALIGN_EN
  ,
  output logic               misalign
`endif
);

  fetch_state_e     state;
  logic             discard;
  logic             redirect;
  logic             issue;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] seq_pc;
`ifdef FETCH_CTRL_MISALIGN_EN
  logic             misaligned;
`endif

  pc_next_sel #(
    .WIDTH(WIDTH)
  ) u_pc_next_sel (
    .pc          (PC),
    .branch_taken(PCsrc),
    .branch_pc   (branch_pc),
    .imm_op      (ImmOp),
    .jalr_en     (jalr_en),
    .jalr_target (jalr_target),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .seq_pc      (seq_pc)
`ifdef FETCH_CTRL_MISALIGN_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  // The request is decoded from state so a 1-cycle memory sustains one fetch every two cycles.
  assign issue     = !rst && (state == ISSUE) && !stall && (!instr_valid || id_ready);
  assign imem_req  = issue;
  assign imem_addr = PC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_S;
      PC          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      flush       <= 1'b0;
      discard     <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_EN
      misalign    <= 1'b0;
`endif
    end else begin
      flush <= redirect;
`ifdef FETCH_CTRL_MISALIGN_EN
      misalign <= redirect && misaligned;
`endif
      if (instr_valid && id_ready) begin
        instr_valid <= 1'b0;
      end

      case (state)
        RESET_S: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            state   <= WAIT;
            discard <= redirect;
          end
        end
        WAIT: begin
          // An ack always ends the outstanding request; a coincident redirect only drops its data.
          if (imem_ack) begin
            state   <= ISSUE;
            discard <= 1'b0;
            if (!discard && !redirect) begin
              instr       <= imem_rdata;
              instr_pc    <= PC;
              instr_valid <= 1'b1;
              PC          <= seq_pc;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state <= RESET_S;
        end
      endcase

      if (redirect) begin
        PC          <= redirect_pc;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a bench-side memory and transaction-level model.
// Define FETCH_CTRL_MISALIGN_EN for both bench and RTL to exercise the misalign feature.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, PCsrc, jalr_en, imem_ack, id_ready;
  logic [31:0] branch_pc, ImmOp, jalr_target, imem_rdata;
  logic        imem_req, instr_valid, flush;
  logic [31:0] imem_addr, instr, instr_pc, PC;
`ifdef FETCH_CTRL_MISALIGN_EN
  logic        misalign;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Bench memory: acknowledges the last observed request after ack_lat cycles.
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  int          ack_lat = 1;
  logic [31:0] pend_addr = '0;

  // Reference model: fetch PC, one outstanding request, one-entry buffer.
  bit          m_rs, m_out, m_disc, m_valid, m_flush, m_mis;
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  bit          exp_req;
  logic [31:0] exp_addr;
  logic        obs_req;
  logic [31:0] obs_addr;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .WIDTH   (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .branch_pc  (branch_pc),
    .ImmOp      (ImmOp),
    .jalr_en    (jalr_en),
    .jalr_target(jalr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .id_ready   (id_ready),
    .PC         (PC),
    .flush      (flush)
`ifdef FETCH_CTRL_MISALIGN_EN
    ,
    .misalign   (misalign)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic idle();
    stall = 1'b0; PCsrc = 1'b0; jalr_en = 1'b0; id_ready = 1'b1;
    branch_pc = '0; ImmOp = '0; jalr_target = '0; ack_lat = 1;
  endtask

  // One clock cycle: drive memory, sample combinational request, advance model, cross the edge.
  task automatic step();
    bit          redir;
    logic [31:0] tgt, tgt_raw;
    if (pend) pend_cnt++;
    imem_ack   = pend && (pend_cnt >= ack_lat);
    imem_rdata = imem_ack ? mem_word(pend_addr) : $urandom;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    redir    = jalr_en || PCsrc;
    tgt_raw  = jalr_en ? jalr_target : branch_pc + ImmOp;
`ifdef FETCH_CTRL_MISALIGN_EN
    tgt = tgt_raw & ~32'h3;
`else
    tgt = tgt_raw;
`endif
    if (rst) begin
      exp_req = 1'b0; m_pc = '0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
      m_flush = 1'b0; m_mis = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_rs = 1'b1;
    end else begin
      exp_req  = !m_rs && !m_out && !stall && (!m_valid || id_ready);
      exp_addr = m_pc;
      if (m_valid && id_ready) m_valid = 1'b0;
      if (exp_req) begin
        m_out = 1'b1; m_disc = redir; m_addr = m_pc;
      end else if (m_out && imem_ack) begin
        if (!m_disc && !redir) begin
          m_valid = 1'b1; m_instr = mem_word(m_addr); m_ipc = m_addr; m_pc = m_pc + 32'd4;
        end
        m_out = 1'b0; m_disc = 1'b0;
      end else if (m_out && redir) begin
        m_disc = 1'b1;
      end
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0;
      end
      m_flush = redir;
      m_mis   = redir && (tgt_raw[1:0] != 2'b00);
      m_rs    = 1'b0;
    end
    if (imem_ack) pend = 1'b0;
    if (obs_req) begin
      pend = 1'b1; pend_cnt = 0; pend_addr = obs_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; PCsrc = 1'b1; branch_pc = 32'h40; ImmOp = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'h0); end
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flush: got %b expected 0", flush); end
      tests_run++; if (instr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
      tests_run++; if (instr_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr_pc: got %h expected 0", instr_pc); end
      if (i > 0) begin
        tests_run++; if (obs_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 0", obs_req); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    int          req_cyc[$];
    logic [31:0] ipcs[$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_req) begin addrs.push_back(obs_addr); req_cyc.push_back(i); end
      if (instr_valid) begin
        ipcs.push_back(instr_pc);
        tests_run++; if (instr !== mem_word(instr_pc)) begin tests_failed++; $display("[TB] FAIL seq_instr: got %h expected %h", instr, mem_word(instr_pc)); end
      end
    end
    tests_run++;
    if (addrs.size() < 3 || ipcs.size() < 3) begin
      tests_failed++; $display("[TB] FAIL seq_count: got %0d reqs %0d instrs expected at least 3 each", addrs.size(), ipcs.size());
    end else begin
      tests_run++; if (req_cyc[0] != 1) begin tests_failed++; $display("[TB] FAIL seq_first_req_cycle: got %0d expected 1", req_cyc[0]); end
      for (int k = 0; k < 3; k++) begin
        tests_run++; if (addrs[k] !== 32'(4 * k)) begin tests_failed++; $display("[TB] FAIL seq_addr%0d: got %h expected %h", k, addrs[k], 32'(4 * k)); end
        tests_run++; if (ipcs[k] !== 32'(4 * k)) begin tests_failed++; $display("[TB] FAIL seq_instr_pc%0d: got %h expected %h", k, ipcs[k], 32'(4 * k)); end
        if (k > 0) begin
          tests_run++; if (req_cyc[k] - req_cyc[k-1] != 2) begin tests_failed++; $display("[TB] FAIL seq_gap%0d: got %0d expected 2", k, req_cyc[k] - req_cyc[k-1]); end
        end
      end
    end
  endtask

  // Redirect on the issue cycle, then expect the next request at the target.
  task automatic redirect_then_fetch(input string name, input logic [31:0] target);
    bit found = 1'b0;
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_flush: got %b expected 1", name, flush); end
    tests_run++; if (PC !== target) begin tests_failed++; $display("[TB] FAIL %s_pc: got %h expected %h", name, PC, target); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_valid: got %b expected 0", name, instr_valid); end
    step();
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_flush_pulse: got %b expected 0", name, flush); end
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_req) begin
        found = 1'b1;
        tests_run++; if (obs_addr !== target) begin tests_failed++; $display("[TB] FAIL %s_next_addr: got %h expected %h", name, obs_addr, target); end
      end
    end
    if (!found) begin tests_run++; tests_failed++; $display("[TB] FAIL %s_timeout: got no request expected one", name); end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    PCsrc = 1'b1; branch_pc = 32'h10; ImmOp = 32'hFFFF_FFF8;
    step();
    idle();
    redirect_then_fetch("branch", 32'h8);
  endtask

  task automatic test_priority();
    do_reset();
    step();
    PCsrc = 1'b1; branch_pc = 32'h10; ImmOp = 32'h20; jalr_en = 1'b1; jalr_target = 32'h100;
    step();
    idle();
    redirect_then_fetch("priority", 32'h100);
  endtask

  task automatic test_jalr_discard();
    bit found = 1'b0;
    bit acked = 1'b0;
    do_reset();
    ack_lat = 3;
    step();
    step();
    tests_run++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL jd_first_req: got %b/%h expected 1/0", obs_req, obs_addr); end
    jalr_en = 1'b1; jalr_target = 32'h40;
    step();
    jalr_en = 1'b0;
    tests_run++; if (PC !== 32'h40) begin tests_failed++; $display("[TB] FAIL jd_pc: got %h expected 40", PC); end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem_ack) acked = 1'b1;
      if (obs_req) begin
        found = 1'b1;
        tests_run++; if (obs_addr !== 32'h40) begin tests_failed++; $display("[TB] FAIL jd_target_addr: got %h expected 40", obs_addr); end
        tests_run++; if (i != 2 || !acked) begin tests_failed++; $display("[TB] FAIL jd_req_timing: got cycle %0d acked %b expected cycle 2 acked 1", i, acked); end
      end else begin
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL jd_dropped_ack: got valid %b expected 0", instr_valid); end
      end
    end
    if (!found) begin tests_run++; tests_failed++; $display("[TB] FAIL jd_timeout: got no request expected one"); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        tests_run++; if (instr_pc !== 32'h40) begin tests_failed++; $display("[TB] FAIL jd_instr_pc: got %h expected 40", instr_pc); end
      end
    end
    if (!found) begin tests_run++; tests_failed++; $display("[TB] FAIL jd_deliver_timeout: got no instruction expected one"); end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    if (!found) begin tests_run++; tests_failed++; $display("[TB] FAIL stall_fill_timeout: got no instruction expected one"); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++; if (obs_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_req%0d: got %b expected 0", i, obs_req); end
      tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
        tests_failed++; $display("[TB] FAIL stall_hold%0d: got %b/%h/%h expected 1/0/%h", i, instr_valid, instr_pc, instr, mem_word(32'h0));
      end
    end
    id_ready = 1'b1;
    step();
    tests_run++; if (obs_req !== 1'b0 || instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_transfer: got req %b valid %b expected 0/0", obs_req, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (obs_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_empty_req%0d: got %b expected 0", i, obs_req); end
    end
    stall = 1'b0;
    step();
    tests_run++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin tests_failed++; $display("[TB] FAIL stall_release: got %b/%h expected 1/4", obs_req, obs_addr); end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    do_reset();
    step();
    jalr_en = 1'b1; jalr_target = 32'hFFFF_FFFC;
    step();
    jalr_en = 1'b0;
    tests_run++; if (PC !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_target: got %h expected fffffffc", PC); end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        tests_run++; if (instr_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_instr_pc: got %h expected fffffffc", instr_pc); end
        tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_pc: got %h expected 0", PC); end
      end
    end
    if (!found) begin tests_run++; tests_failed++; $display("[TB] FAIL wrap_timeout: got no instruction expected one"); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ack_lat = 2;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    tests_run++; if (imem_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmw_stale_ack_driven: got %b expected 1", imem_ack); end
    tests_run++; if (instr_valid !== 1'b0 || PC !== 32'h0) begin tests_failed++; $display("[TB] FAIL rmw_ignored: got valid %b pc %h expected 0/0", instr_valid, PC); end
    step();
    tests_run++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rmw_refetch: got %b/%h expected 1/0", obs_req, obs_addr); end
  endtask

`ifdef FETCH_CTRL_MISALIGN_EN
  task automatic test_misalign();
    do_reset();
    step();
    jalr_en = 1'b1; jalr_target = 32'h102;
    step();
    idle();
    tests_run++; if (misalign !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_pulse: got %b expected 1", misalign); end
    tests_run++; if (PC !== 32'h100) begin tests_failed++; $display("[TB] FAIL mis_pc: got %h expected 100", PC); end
    PCsrc = 1'b1; branch_pc = 32'h200; ImmOp = 32'h0;
    step();
    idle();
    tests_run++; if (misalign !== 1'b0 || PC !== 32'h200) begin tests_failed++; $display("[TB] FAIL mis_aligned: got %b/%h expected 0/200", misalign, PC); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      id_ready    = ($urandom_range(0, 9) < 6);
      jalr_en     = ($urandom_range(0, 19) == 0);
      PCsrc       = ($urandom_range(0, 11) == 0);
      branch_pc   = $urandom & 32'h0000_FFFC;
      ImmOp       = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom & 32'h0000_00FC);
      jalr_target = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
      ack_lat     = $urandom_range(1, 4);
      step();
      tests_run++; if (obs_req !== exp_req) begin tests_failed++; $display("[TB] FAIL rnd_req@%0d: got %b expected %b", i, obs_req, exp_req); end
      if (exp_req) begin
        tests_run++; if (obs_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL rnd_addr@%0d: got %h expected %h", i, obs_addr, exp_addr); end
      end
      tests_run++; if (PC !== m_pc) begin tests_failed++; $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", i, PC, m_pc); end
      tests_run++; if (instr_valid !== m_valid) begin tests_failed++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", i, instr_valid, m_valid); end
      tests_run++; if (flush !== m_flush) begin tests_failed++; $display("[TB] FAIL rnd_flush@%0d: got %b expected %b", i, flush, m_flush); end
      if (m_valid) begin
        tests_run++; if (instr !== m_instr || instr_pc !== m_ipc) begin
          tests_failed++; $display("[TB] FAIL rnd_buffer@%0d: got %h/%h expected %h/%h", i, instr, instr_pc, m_instr, m_ipc);
        end
      end
`ifdef FETCH_CTRL_MISALIGN_EN
      tests_run++; if (misalign !== m_mis) begin tests_failed++; $display("[TB] FAIL rnd_misalign@%0d: got %b expected %b", i, misalign, m_mis); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_jalr_discard();
    test_stall();
    test_wrap();
    test_reset_mid_wait();
`ifdef FETCH_CTRL_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
